// File: rtl/fidus_reset_seq_bfm.sv
// Multi-channel reset sequencer: asserts a channel set together, holds it, then
// releases the channels one by one in ascending index order with a fixed stagger.
module fidus_reset_seq_bfm #(
  parameter                    BFM_NAME        = "bfm_reset_seq",
  parameter int                NUM_CH          = 4,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b1}},
  parameter int                ASSERT_CYCLES   = 16,
  parameter int                STAGGER_CYCLES  = 8,
  parameter bit                AUTO_RELEASE    = 1'b1,
  parameter bit                AUTO_START      = 1'b1,
  parameter int                CNT_W           = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_assert,
  input  logic              i_req_release,
  input  logic [NUM_CH-1:0] i_ch_mask,
  output logic [NUM_CH-1:0] o_bfm_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_all_released
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL, RELEASE} state_e;

  localparam bit PARAMS_OK = (NUM_CH >= 1) && (NUM_CH <= 32) && (ASSERT_CYCLES >= 1) &&
                             (STAGGER_CYCLES >= 0) && ($bits(BFM_NAME) > 0) &&
                             ((CNT_W >= 31) || ((ASSERT_CYCLES < (1 << CNT_W)) &&
                                                (STAGGER_CYCLES < (1 << CNT_W))));

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   act_q, act_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic                start_pend_q, start_pend_d;
  logic [NUM_CH-1:0]   bfm_rst_q, bfm_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                all_rel_q, all_rel_d;

  logic                req_ok;
  logic                do_rel;
  logic                found;
  logic [NUM_CH-1:0]   clr;

  // pend_q holds the selected channels that have not been released yet; a new
  // assert request always wins over release activity and restarts the hold.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_d        = act_q;
    pend_d       = pend_q;
    start_pend_d = 1'b0;
    done_d       = 1'b0;
    do_rel       = 1'b0;
    found        = 1'b0;
    clr          = '0;
    req_ok       = i_req_assert && (i_ch_mask != '0);

    if (req_ok) begin
      pend_d  = i_ch_mask;
      act_d   = act_q | i_ch_mask;
      cnt_d   = CNT_W'(1);
      state_d = HOLD;
    end else begin
      case (state_q)
        IDLE: begin
          if (AUTO_START && start_pend_q) begin
            pend_d  = '1;
            act_d   = '1;
            cnt_d   = CNT_W'(1);
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == CNT_W'(ASSERT_CYCLES)) begin
            if (AUTO_RELEASE) do_rel = 1'b1;
            else              state_d = WAIT_REL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (i_req_release) do_rel = 1'b1;
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STAGGER_CYCLES)) do_rel = 1'b1;
          else                                 cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    // Unselected indices are skipped by the priority pick, so they cost no cycles.
    if (do_rel) begin
      if (STAGGER_CYCLES == 0) begin
        clr = pend_q;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pend_q[i] && !found) begin
            clr[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
      act_d  = act_q & ~clr;
      pend_d = pend_q & ~clr;
      cnt_d  = CNT_W'(1);
      if (pend_d == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end

    bfm_rst_d = act_d ^ ACTIVE_LOW_MASK;
    busy_d    = (state_d != IDLE);
    all_rel_d = (act_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      act_q        <= '1;
      pend_q       <= '0;
      start_pend_q <= 1'b1;
      bfm_rst_q    <= ~ACTIVE_LOW_MASK;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      all_rel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      start_pend_q <= start_pend_d;
      bfm_rst_q    <= bfm_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      all_rel_q    <= all_rel_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (PARAMS_OK);
  end

  assign o_bfm_rst      = bfm_rst_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_all_released = all_rel_q;

endmodule

// File: tb/tb_fidus_reset_seq_bfm.sv
// Directed bench for fidus_reset_seq_bfm: three instances cover auto release,
// manual release and zero-stagger configurations.
module tb_fidus_reset_seq_bfm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req_a = 1'b0, rel_a = 1'b0;
  logic [3:0] mask_a = 4'b0;
  logic [3:0] out_a;
  logic       busy_a, done_a, all_a;

  logic       req_b = 1'b0, rel_b = 1'b0;
  logic [3:0] mask_b = 4'b0;
  logic [3:0] out_b;
  logic       busy_b, done_b, all_b;

  logic       req_c = 1'b0, rel_c = 1'b0;
  logic [3:0] mask_c = 4'b0;
  logic [3:0] out_c;
  logic       busy_c, done_c, all_c;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_act;

  always #5 clk = ~clk;

  fidus_reset_seq_bfm #(
    .NUM_CH(4), .ACTIVE_LOW_MASK(4'b0011), .ASSERT_CYCLES(16), .STAGGER_CYCLES(8),
    .AUTO_RELEASE(1'b1), .AUTO_START(1'b1), .CNT_W(16)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_assert(req_a), .i_req_release(rel_a),
    .i_ch_mask(mask_a), .o_bfm_rst(out_a), .o_busy(busy_a), .o_done(done_a),
    .o_all_released(all_a)
  );

  fidus_reset_seq_bfm #(
    .NUM_CH(4), .ACTIVE_LOW_MASK(4'b0000), .ASSERT_CYCLES(16), .STAGGER_CYCLES(8),
    .AUTO_RELEASE(1'b0), .AUTO_START(1'b0), .CNT_W(16)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_assert(req_b), .i_req_release(rel_b),
    .i_ch_mask(mask_b), .o_bfm_rst(out_b), .o_busy(busy_b), .o_done(done_b),
    .o_all_released(all_b)
  );

  fidus_reset_seq_bfm #(
    .NUM_CH(4), .ACTIVE_LOW_MASK(4'b1111), .ASSERT_CYCLES(16), .STAGGER_CYCLES(0),
    .AUTO_RELEASE(1'b1), .AUTO_START(1'b0), .CNT_W(16)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .i_req_assert(req_c), .i_req_release(rel_c),
    .i_ch_mask(mask_c), .o_bfm_rst(out_c), .o_busy(busy_c), .o_done(done_c),
    .o_all_released(all_c)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag,
                              input logic [3:0] rst_obs, input logic busy_obs,
                              input logic done_obs, input logic all_obs,
                              input logic [3:0] rst_exp, input logic busy_exp,
                              input logic done_exp, input logic all_exp);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {rst_obs, busy_obs, done_obs, all_obs};
    exp = {rst_exp, busy_exp, done_exp, all_exp};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed rst/busy/done/all=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] r, input logic b,
                         input logic d, input logic a);
    check_output(tag, out_a, busy_a, done_a, all_a, r, b, d, a);
  endtask

  task automatic check_b(input string tag, input logic [3:0] r, input logic b,
                         input logic d, input logic a);
    check_output(tag, out_b, busy_b, done_b, all_b, r, b, d, a);
  endtask

  task automatic check_c(input string tag, input logic [3:0] r, input logic b,
                         input logic d, input logic a);
    check_output(tag, out_c, busy_c, done_c, all_c, r, b, d, a);
  endtask

  initial begin
    // Reset state, then automatic full-mask start with staggered release.
    tick(5);
    check_a("a_in_reset", 4'b1100, 1'b0, 1'b0, 1'b0);
    check_b("b_in_reset", 4'b1111, 1'b0, 1'b0, 1'b0);
    check_c("c_in_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      tick(1);
      exp_act = 4'b1111;
      if (k >= 17) exp_act[0] = 1'b0;
      if (k >= 25) exp_act[1] = 1'b0;
      if (k >= 33) exp_act[2] = 1'b0;
      if (k >= 41) exp_act[3] = 1'b0;
      check_a($sformatf("t1_autostart_k%0d", k), exp_act ^ 4'b0011, k < 41, k == 41, k >= 41);
    end
    check_b("b_idle_after_reset", 4'b1111, 1'b0, 1'b0, 1'b0);
    check_c("c_idle_after_reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Partial mask: only ch1 and ch3 move, unselected channels stay released.
    mask_a = 4'b1010;
    req_a  = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      if (k == 1) req_a = 1'b0;
      exp_act = {k < 25, 1'b0, k < 17, 1'b0};
      check_a($sformatf("t2_mask1010_k%0d", k), exp_act ^ 4'b0011, k < 25, k == 25, k >= 25);
    end

    // Restart during release after ch0 has already been released.
    mask_a = 4'b1111;
    req_a  = 1'b1;
    for (int k = 1; k <= 59; k++) begin
      tick(1);
      if (k == 1 || k == 18) req_a = 1'b0;
      if (k < 17)        exp_act = 4'b1111;
      else if (k == 17)  exp_act = 4'b1110;
      else begin
        exp_act = 4'b1111;
        if (k >= 34) exp_act[0] = 1'b0;
        if (k >= 42) exp_act[1] = 1'b0;
        if (k >= 50) exp_act[2] = 1'b0;
        if (k >= 58) exp_act[3] = 1'b0;
      end
      check_a($sformatf("t4_restart_k%0d", k), exp_act ^ 4'b0011, k < 58, k == 58, k >= 58);
      if (k == 17) req_a = 1'b1;
    end

    // Manual release: early release pulse dropped, waits indefinitely after hold.
    mask_b = 4'b1111;
    req_b  = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick(1);
      if (k == 1) req_b = 1'b0;
      if (k == 6) rel_b = 1'b0;
      check_b($sformatf("t3_hold_wait_k%0d", k), 4'b1111, 1'b1, 1'b0, 1'b0);
      if (k == 5) rel_b = 1'b1;
    end

    // Assert and release together: assert wins, ch2/ch3 outside new mask untouched.
    mask_b = 4'b0011;
    req_b  = 1'b1;
    rel_b  = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick(1);
      if (j == 1 || j == 21) begin
        req_b = 1'b0;
        rel_b = 1'b0;
      end
      exp_act = 4'b1111;
      if (j >= 21) exp_act[0] = 1'b0;
      if (j >= 29) exp_act[1] = 1'b0;
      check_b($sformatf("t5_simul_j%0d", j), exp_act, j < 29, j == 29, 1'b0);
      if (j == 20) rel_b = 1'b1;
    end

    // Zero mask is ignored entirely.
    mask_c = 4'b0000;
    req_c  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k == 1) req_c = 1'b0;
      check_c($sformatf("t6_zero_mask_k%0d", k), 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    // Zero stagger: all channels release on one edge.
    mask_c = 4'b1111;
    req_c  = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (k == 1) req_c = 1'b0;
      exp_act = (k < 17) ? 4'b1111 : 4'b0000;
      check_c($sformatf("t6_stagger0_k%0d", k), ~exp_act, k < 17, k == 17, k >= 17);
    end

    // Reset in the middle of a release forces everything asserted with no done.
    mask_a = 4'b1111;
    req_a  = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick(1);
      if (k == 1) req_a = 1'b0;
      if (k < 17)      exp_act = 4'b1111;
      else if (k < 25) exp_act = 4'b1110;
      else if (k < 27) exp_act = 4'b1100;
      else             exp_act = 4'b1111;
      check_a($sformatf("t5_mid_rst_k%0d", k), exp_act ^ 4'b0011, k < 27, 1'b0, 1'b0);
      if (k == 26) rst = 1'b1;
    end
    rst = 1'b0;
    tick(1);
    check_a("a_restart_after_rst", 4'b1100, 1'b1, 1'b0, 1'b0);
    check_b("b_idle_after_rst", 4'b1111, 1'b0, 1'b0, 1'b0);
    check_c("c_idle_after_rst", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
